// File: rtl/on_off_link_tx_pkg.sv
// on_off_link_tx_pkg: flit format, flit type and framing state shared by the link transmitter.
package on_off_link_tx_pkg;
  localparam int FLIT_W = 16;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 14;
  typedef logic [FLIT_W-1:0] flit_Data;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_Type;
  typedef enum logic {TX_IDLE, TX_IN_PKT} tx_State_t;
  function automatic flit_Type flit_type(input flit_Data f);
    return flit_Type'(f[TYPE_MSB:TYPE_LSB]);
  endfunction
endpackage

// File: rtl/link_tx_fifo.sv
// link_tx_fifo: DEPTH-entry flit FIFO with combinational head and registered occupancy.
module link_tx_fifo
  import on_off_link_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  flit_Data                 din,
  output flit_Data                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  flit_Data mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/on_off_link_tx.sv
// on_off_link_tx: on/off flow-controlled link transmitter with framing checker.
// Define LINK_TX_STATS_EN to add saturating flits_sent_o / stall_cycles_o counters.
module on_off_link_tx
  import on_off_link_tx_pkg::*;
#(
  parameter int SKID_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  flit_Data    flit_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        on_off_i,
  output flit_Data    flit_o,
  output logic        flit_valid_o,
  output logic        pkt_open_o,
  output logic        proto_err_o
`ifdef LINK_TX_STATS_EN
  ,
  output logic [31:0] flits_sent_o,
  output logic [31:0] stall_cycles_o
`endif
);
  logic on_q, empty, push, pop;
  logic [$clog2(SKID_DEPTH):0] count;
  flit_Data head;
  flit_Type t;
  tx_State_t state;
  assign ready_o = count != ($clog2(SKID_DEPTH)+1)'(SKID_DEPTH);
  assign push = valid_i && ready_o;
  assign pop = on_q && !empty;
  assign t = flit_type(head);
  assign pkt_open_o = state == TX_IN_PKT;
  link_tx_fifo #(.DEPTH(SKID_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(flit_i),
    .head(head), .count(count), .empty(empty)
  );
  // A misplaced HEAD/HEADTAIL still restarts framing as its own type.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_q <= 1'b0;
      flit_o <= '0;
      flit_valid_o <= 1'b0;
      state <= TX_IDLE;
      proto_err_o <= 1'b0;
    end else begin
      on_q <= on_off_i;
      flit_valid_o <= pop;
      if (pop) begin
        flit_o <= head;
        if (state == TX_IDLE ? (t == BODY || t == TAIL) : (t == HEAD || t == HEADTAIL))
          proto_err_o <= 1'b1;
        state <= (t == HEAD || (state == TX_IN_PKT && t == BODY)) ? TX_IN_PKT : TX_IDLE;
      end
    end
  end
`ifdef LINK_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flits_sent_o <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (pop && ~&flits_sent_o) flits_sent_o <= flits_sent_o + 1'b1;
      if (!on_q && !empty && ~&stall_cycles_o) stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_on_off_link_tx.sv
// tb_on_off_link_tx: directed stimulus against a queue-based model of the link transmitter.
module tb_on_off_link_tx;
  import on_off_link_tx_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, on_off_i = 1'b0;
  flit_Data flit_i = '0;
  logic ready_o, flit_valid_o, pkt_open_o, proto_err_o;
  flit_Data flit_o;
`ifdef LINK_TX_STATS_EN
  logic [31:0] flits_sent_o, stall_cycles_o;
  int m_sent, m_stall;
`endif
  on_off_link_tx #(.SKID_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o),
    .on_off_i(on_off_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
    .pkt_open_o(pkt_open_o), .proto_err_o(proto_err_o)
`ifdef LINK_TX_STATS_EN
    , .flits_sent_o(flits_sent_o), .stall_cycles_o(stall_cycles_o)
`endif
  );
  always #5 clk = ~clk;

  int npass = 0, ntot = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else npass++;
  endtask

  function automatic flit_Data mk(input flit_Type ty, input int pl);
    return {ty, 14'(pl)};
  endfunction

  // Model: link buffer as a queue, framing as "inside a packet" flag.
  flit_Data q[$];
  flit_Data m_fo, m_f;
  logic m_on, m_fv, m_open, m_err, m_init = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      {m_on, m_fv, m_open, m_err} = '0;
      m_fo = '0;
      m_init = 1'b1;
`ifdef LINK_TX_STATS_EN
      m_sent = 0;
      m_stall = 0;
`endif
    end else begin
      automatic bit can_push = valid_i && q.size() != 4;
`ifdef LINK_TX_STATS_EN
      if (!m_on && q.size() != 0) m_stall++;
`endif
      m_fv = m_on && q.size() != 0;
      if (m_fv) begin
        m_f = q.pop_front();
        m_fo = m_f;
`ifdef LINK_TX_STATS_EN
        m_sent++;
`endif
        case (flit_type(m_f))
          HEAD:     begin if (m_open) m_err = 1'b1; m_open = 1'b1; end
          HEADTAIL: begin if (m_open) m_err = 1'b1; m_open = 1'b0; end
          BODY:     if (!m_open) m_err = 1'b1;
          default:  begin if (!m_open) m_err = 1'b1; m_open = 1'b0; end
        endcase
      end
      if (can_push) q.push_back(flit_i);
      m_on = on_off_i;
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("flit_valid", flit_valid_o, m_fv);
    chk("flit_data", flit_o, m_fo);
    chk("ready", ready_o, q.size() != 4);
    chk("pkt_open", pkt_open_o, m_open);
    chk("proto_err", proto_err_o, m_err);
`ifdef LINK_TX_STATS_EN
    chk("flits_sent", flits_sent_o, m_sent);
    chk("stall_cycles", stall_cycles_o, m_stall);
`endif
  end

  task automatic put(input flit_Data f);
    int n = 0;
    @(negedge clk);
    flit_i = f;
    valid_i = 1'b1;
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("put_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", flit_valid_o, 0);
    chk("rst_flit", flit_o, 0);
    rst_n = 1'b1;
    on_off_i = 1'b1;
    repeat (2) @(negedge clk);
    // packet streamed back to back
    put(mk(HEAD, 1)); put(mk(BODY, 2)); put(mk(TAIL, 3));
    idle(1);
    chk("t1_tail_data", flit_o, mk(TAIL, 3));
    chk("t1_tail_valid", flit_valid_o, 1);
    chk("t1_closed", pkt_open_o, 0);
    repeat (3) @(negedge clk);
    // fill while off, fifth flit held by source
    on_off_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) put(mk(HEADTAIL, 16 + i));
    @(negedge clk);
    flit_i = mk(HEADTAIL, 20);
    chk("t2_full_ready", ready_o, 0);
    repeat (3) @(negedge clk);
    chk("t2_stalled", flit_valid_o, 0);
    on_off_i = 1'b1;
    begin
      int n = 0;
      while (!ready_o && n < 20) begin @(negedge clk); n++; end
      chk("t2_ready_back", n < 20, 1);
    end
    idle(8);
    // full with continuous push and pop, pointers wrap
    on_off_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) put(mk(HEADTAIL, 32 + i));
    on_off_i = 1'b1;
    for (int i = 0; i < 9; i++) put(mk(HEADTAIL, 40 + i));
    idle(8);
    // stall mid-packet
    put(mk(HEAD, 64)); put(mk(BODY, 65));
    on_off_i = 1'b0;
    put(mk(TAIL, 66));
    idle(3);
    chk("t4_open_stall", pkt_open_o, 1);
    chk("t4_no_valid", flit_valid_o, 0);
    on_off_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_tail_sent", flit_o, mk(TAIL, 66));
    chk("t4_closed", pkt_open_o, 0);
    // framing errors
    chk("t5_no_err_yet", proto_err_o, 0);
    put(mk(BODY, 80));
    idle(3);
    chk("t5_err_body", proto_err_o, 1);
    chk("t5_body_sent", flit_o, mk(BODY, 80));
    put(mk(HEAD, 81)); put(mk(HEAD, 82)); put(mk(TAIL, 83));
    idle(4);
    chk("t5_err_sticky", proto_err_o, 1);
    chk("t5_last", flit_o, mk(TAIL, 83));
    // reset with flits queued
    on_off_i = 1'b0;
    repeat (2) @(negedge clk);
    put(mk(HEAD, 96)); put(mk(BODY, 97)); put(mk(TAIL, 98));
    idle(0);
    chk("t6_pre_ready", ready_o, 1);
    rst_n = 1'b0;
    on_off_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_valid", flit_valid_o, 0);
    chk("t6_ready", ready_o, 1);
    chk("t6_open", pkt_open_o, 0);
    chk("t6_err", proto_err_o, 0);
`ifdef LINK_TX_STATS_EN
    chk("t6_sent_zero", flits_sent_o, 0);
`endif
    repeat (4) @(negedge clk);
    chk("t6_flushed", flit_valid_o, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
